snake_body_store: RTL

- Upstream state store for the snake VGA renderer. Holds the coordinates of every snake segment, advances the snake one grid cell per step request, and handles growth, wall collision and self collision.
- The draw/erase FSM reads segment coordinates through a combinational read port, indexed by segment number.
- It issues `step` once per animation tick, after erase and before redraw.

---
 rtl/snake_pkg.sv | 36 +++
 rtl/snake_next_head.sv | 72 +++++++
 rtl/snake_body_store.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the snake state store.
//   - dir_t    : movement direction encoding (right/down/up/left)
//   - state_t  : step FSM states
//   - rev_dir  : the opposite of a direction
//   - XSCREEN/YSCREEN/XDIM/YDIM : screen size and grid cell size in pixels
package snake_pkg;

    localparam int XSCREEN = 160;
    localparam int YSCREEN = 120;
    localparam int XDIM    = 10;
    localparam int YDIM    = 10;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_UP    = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MOVE  = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic dir_t rev_dir(input dir_t d);
        case (d)
            DIR_RIGHT: rev_dir = DIR_LEFT;
            DIR_LEFT:  rev_dir = DIR_RIGHT;
            DIR_UP:    rev_dir = DIR_DOWN;
            default:   rev_dir = DIR_UP;
        endcase
    endfunction

endpackage

// File: rtl/snake_next_head.sv
// Combinational proposed-head calculator.
// Ports:
//   head_x_i/head_y_i : current head coordinates
//   dir_i             : direction of travel
//   next_x_o/next_y_o : head after one cell of movement
//   blocked_o         : move would leave the screen (always 0 when wrapping)
// Macro SNAKE_WRAP_EN: when defined, leaving one edge re-enters at the
// opposite edge instead of blocking.
module snake_next_head
    import snake_pkg::*;
(
    input  logic [7:0] head_x_i,
    input  logic [6:0] head_y_i,
    input  dir_t       dir_i,
    output logic [7:0] next_x_o,
    output logic [6:0] next_y_o,
    output logic       blocked_o
);

`ifdef SNAKE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    localparam logic [7:0] XSTEP = 8'(XDIM);
    localparam logic [7:0] XLAST = 8'(XSCREEN - XDIM);
    localparam logic [6:0] YSTEP = 7'(YDIM);
    localparam logic [6:0] YLAST = 7'(YSCREEN - YDIM);

    // Each edge test guards the add/subtract, so no result leaves its width.
    always_comb begin
        next_x_o  = head_x_i;
        next_y_o  = head_y_i;
        blocked_o = 1'b0;
        case (dir_i)
            DIR_RIGHT: begin
                if (head_x_i >= XLAST) begin
                    if (WRAP) next_x_o  = 8'd0;
                    else      blocked_o = 1'b1;
                end else begin
                    next_x_o = head_x_i + XSTEP;
                end
            end
            DIR_LEFT: begin
                if (head_x_i < XSTEP) begin
                    if (WRAP) next_x_o  = XLAST;
                    else      blocked_o = 1'b1;
                end else begin
                    next_x_o = head_x_i - XSTEP;
                end
            end
            DIR_DOWN: begin
                if (head_y_i >= YLAST) begin
                    if (WRAP) next_y_o  = 7'd0;
                    else      blocked_o = 1'b1;
                end else begin
                    next_y_o = head_y_i + YSTEP;
                end
            end
            default: begin
                if (head_y_i < YSTEP) begin
                    if (WRAP) next_y_o  = YLAST;
                    else      blocked_o = 1'b1;
                end else begin
                    next_y_o = head_y_i - YSTEP;
                end
            end
        endcase
    end

endmodule

// File: rtl/snake_body_store.sv
// Snake segment store: holds every segment coordinate, advances the snake
// one cell per step request, handles growth, wall and self collision.
// Ports:
//   CLOCK_50, Resetn (synchronous, active-low)
//   step, dir, grow       : step request, requested direction, apple pulse
//   rd_idx -> rd_x, rd_y  : combinational segment read (0 = head)
//   length                : current segment count
//   busy, done            : FSM not idle / one-cycle end-of-step pulse
//   collide_wall, collide_self, game_over : sticky collision status
// Optional macro SNAKE_WRAP_EN (in snake_next_head) makes edges wrap.
module snake_body_store
    import snake_pkg::*;
#(
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 2,
    parameter int X0       = 40,
    parameter int Y0       = 60
) (
    input  logic                       CLOCK_50,
    input  logic                       Resetn,
    input  logic                       step,
    input  logic [1:0]                 dir,
    input  logic                       grow,
    input  logic [$clog2(MAX_LEN)-1:0] rd_idx,
    output logic [7:0]                 rd_x,
    output logic [6:0]                 rd_y,
    output logic [$clog2(MAX_LEN):0]   length,
    output logic                       busy,
    output logic                       done,
    output logic                       collide_wall,
    output logic                       collide_self,
    output logic                       game_over
);

    localparam int IW = $clog2(MAX_LEN);
    localparam int LW = IW + 1;

    state_t          state_q, state_d;
    logic [7:0]      seg_x_q [MAX_LEN];
    logic [6:0]      seg_y_q [MAX_LEN];
    logic [LW-1:0]   length_q, length_d;
    dir_t            cur_dir_q, cur_dir_d;
    dir_t            eff_dir_q, eff_dir_d;
    logic            pend_grow_q, pend_grow_d;
    logic [IW-1:0]   chk_idx_q, chk_idx_d;
    logic            wall_q, wall_d;
    logic            self_q, self_d;
    logic            shift_en;

    dir_t            req_dir, step_dir;
    logic [7:0]      nxt_x;
    logic [6:0]      nxt_y;
    logic            nxt_blocked;

    snake_next_head u_next_head (
        .head_x_i  (seg_x_q[0]),
        .head_y_i  (seg_y_q[0]),
        .dir_i     (eff_dir_q),
        .next_x_o  (nxt_x),
        .next_y_o  (nxt_y),
        .blocked_o (nxt_blocked)
    );

    // A request to reverse onto the body is ignored; keep going straight.
    assign req_dir  = dir_t'(dir);
    assign step_dir = (req_dir == rev_dir(cur_dir_q)) ? cur_dir_q : req_dir;

    always_comb begin
        state_d     = state_q;
        length_d    = length_q;
        cur_dir_d   = cur_dir_q;
        eff_dir_d   = eff_dir_q;
        chk_idx_d   = chk_idx_q;
        wall_d      = wall_q;
        self_d      = self_q;
        pend_grow_d = pend_grow_q | grow;
        shift_en    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (step && !(wall_q || self_q)) begin
                    eff_dir_d = step_dir;
                    state_d   = S_MOVE;
                end
            end
            S_MOVE: begin
                if (nxt_blocked) begin
                    wall_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    shift_en  = 1'b1;
                    cur_dir_d = eff_dir_q;
                    // The shifted-out old tail stays duplicated at index
                    // length, so bumping length keeps it as the new tail.
                    if (pend_grow_q && (length_q < LW'(MAX_LEN)))
                        length_d = length_q + LW'(1);
                    // A pulse landing in this cycle belongs to the next step.
                    pend_grow_d = grow;
                    chk_idx_d   = IW'(1);
                    state_d     = S_CHECK;
                end
            end
            S_CHECK: begin
                if ((seg_x_q[0] == seg_x_q[chk_idx_q]) &&
                    (seg_y_q[0] == seg_y_q[chk_idx_q]))
                    self_d = 1'b1;
                if ({1'b0, chk_idx_q} == (length_q - LW'(1)))
                    state_d = S_DONE;
                else
                    chk_idx_d = chk_idx_q + IW'(1);
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            state_q     <= S_IDLE;
            length_q    <= LW'(INIT_LEN);
            cur_dir_q   <= DIR_RIGHT;
            eff_dir_q   <= DIR_RIGHT;
            pend_grow_q <= 1'b0;
            chk_idx_q   <= '0;
            wall_q      <= 1'b0;
            self_q      <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                if (i < INIT_LEN) begin
                    seg_x_q[i] <= 8'(X0 - i * XDIM);
                    seg_y_q[i] <= 7'(Y0);
                end else begin
                    seg_x_q[i] <= 8'd0;
                    seg_y_q[i] <= 7'd0;
                end
            end
        end else begin
            state_q     <= state_d;
            length_q    <= length_d;
            cur_dir_q   <= cur_dir_d;
            eff_dir_q   <= eff_dir_d;
            pend_grow_q <= pend_grow_d;
            chk_idx_q   <= chk_idx_d;
            wall_q      <= wall_d;
            self_q      <= self_d;
            if (shift_en) begin
                for (int i = MAX_LEN - 1; i > 0; i--) begin
                    seg_x_q[i] <= seg_x_q[i-1];
                    seg_y_q[i] <= seg_y_q[i-1];
                end
                seg_x_q[0] <= nxt_x;
                seg_y_q[0] <= nxt_y;
            end
        end
    end

    assign rd_x         = seg_x_q[rd_idx];
    assign rd_y         = seg_y_q[rd_idx];
    assign length       = length_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign collide_wall = wall_q;
    assign collide_self = self_q;
    assign game_over    = wall_q | self_q;

endmodule
